// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter and its
// round-robin picker.
package uart_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Index width for n requesters; never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority encoder: returns the first asserted request at or after
// last_owner+1, wrapping modulo NREQ.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int  NREQ = 2,
  localparam int IDW  = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  last_owner_i,
  output logic            any_o,
  output logic [IDW-1:0]  pick_o
);

  always_comb begin
    int idx;
    any_o  = 1'b0;
    pick_o = '0;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_owner_i) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any_o && req_i[IDW'(idx)]) begin
        any_o  = 1'b1;
        pick_o = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART transmit path between
// NREQ byte streams, with a stall watchdog that frees a silent owner.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int  NREQ    = 2,
  parameter int  TIMEOUT = 4096,
  localparam int IDW     = idx_width(NREQ)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [NREQ-1:0]        req_valid_i,
  input  logic [BYTE_W*NREQ-1:0] req_data_i,
  input  logic [NREQ-1:0]        req_last_i,
  output logic [NREQ-1:0]        req_ready_o,
  output logic                   tx_valid_o,
  output logic [BYTE_W-1:0]      tx_data_o,
  input  logic                   tx_ready_i,
  output logic [IDW-1:0]         grant_id_o,
  output logic                   busy_o,
  output logic                   timeout_evt_o
);

  localparam int              CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]   WD_LAST   = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IDW-1:0]  LAST_INIT = IDW'(NREQ - 1);

  arb_state_e         state_q, state_d;
  logic [IDW-1:0]     grant_q, grant_d;
  logic [IDW-1:0]     last_owner_q, last_owner_d;
  logic [CW-1:0]      wd_q, wd_d;
  logic               timeout_q, timeout_d;

  logic               pick_any;
  logic [IDW-1:0]     pick_idx;
  logic [BYTE_W-1:0]  req_byte [NREQ];
  logic               own_valid;
  logic               own_last;
  logic [BYTE_W-1:0]  own_data;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign req_byte[g] = req_data_i[g*BYTE_W +: BYTE_W];
  end

  assign own_valid = req_valid_i[grant_q];
  assign own_last  = req_last_i[grant_q];
  assign own_data  = req_byte[grant_q];

  uart_rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req_i        (req_valid_i),
    .last_owner_i (last_owner_q),
    .any_o        (pick_any),
    .pick_o       (pick_idx)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_owner_q <= LAST_INIT;
      wd_q         <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_owner_q <= last_owner_d;
      wd_q         <= wd_d;
      timeout_q    <= timeout_d;
    end
  end

  // While locked the owner is wired straight through; the watchdog only
  // advances on cycles where the owner presents nothing.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_owner_d = last_owner_q;
    wd_d         = wd_q;
    timeout_d    = 1'b0;
    tx_valid_o   = 1'b0;
    tx_data_o    = '0;
    req_ready_o  = '0;

    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = LOCKED;
        end
      end

      LOCKED: begin
        tx_valid_o           = own_valid;
        tx_data_o            = own_valid ? own_data : '0;
        req_ready_o[grant_q] = tx_ready_i;
        if (own_valid) begin
          wd_d = '0;
          if (tx_ready_i && own_last) begin
            state_d      = IDLE;
            last_owner_d = grant_q;
          end
        end else if (TIMEOUT != 0) begin
          if (wd_q == WD_LAST) begin
            state_d      = IDLE;
            last_owner_d = grant_q;
            timeout_d    = 1'b1;
            wd_d         = '0;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign grant_id_o    = grant_q;
  assign busy_o        = (state_q == LOCKED);
  assign timeout_evt_o = timeout_q;

endmodule
